// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: multicycle HI/LO multiply/divide unit with MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module e_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
`ifdef MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif
   localparam int MAXL = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
   localparam int CW = $clog2(MAXL + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb;
   logic [3:0]       rop;
   logic             is_mul, is_div, sgn_mul, sgn_div, na, nb, div_op;
   logic [2*WIDTH-1:0] ma, mb, prod, acc, mres;
   logic [WIDTH-1:0] ua, ub, uq, ur, q, r;
   always_comb begin
      is_mul  = op == 4'd1 || op == 4'd2 || (MADD_EN && op >= 4'd7 && op <= 4'd10);
      is_div  = op == 4'd3 || op == 4'd4;
      sgn_mul = rop == 4'd1 || rop == 4'd7 || rop == 4'd9;
      ma      = sgn_mul ? {{WIDTH{ra[WIDTH-1]}}, ra} : {{WIDTH{1'b0}}, ra};
      mb      = sgn_mul ? {{WIDTH{rb[WIDTH-1]}}, rb} : {{WIDTH{1'b0}}, rb};
      prod    = ma * mb;
      acc     = {hi, lo};
      mres    = (rop == 4'd7 || rop == 4'd8) ? acc + prod :
                (rop == 4'd9 || rop == 4'd10) ? acc - prod : prod;
      // signed divide via magnitudes: quotient truncates, remainder follows dividend
      sgn_div = rop == 4'd3;
      na      = sgn_div && ra[WIDTH-1];
      nb      = sgn_div && rb[WIDTH-1];
      ua      = na ? -ra : ra;
      ub      = nb ? -rb : rb;
      uq      = ub == '0 ? '0 : ua / ub;
      ur      = ub == '0 ? '0 : ua % ub;
      q       = (na ^ nb) ? -uq : uq;
      r       = na ? -ur : ur;
      div_op  = rop == 4'd3 || rop == 4'd4;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         ra    <= '0;
         rb    <= '0;
         rop   <= '0;
      end else if (state == IDLE) begin
         if (start && (is_mul || is_div)) begin
            ra    <= a;
            rb    <= b;
            rop   <= op;
            cnt   <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            state <= RUN;
            busy  <= 1'b1;
         end else if (start && op == 4'd5) begin
            hi <= a;
         end else if (start && op == 4'd6) begin
            lo <= a;
         end
      end else begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!div_op) {hi, lo} <= mres;
            else if (rb != '0) {hi, lo} <= {r, q};
         end
      end
   end
endmodule
